// File: rtl/div_sched.sv
// ---------------------------------------------------------------------------
// div_sched -- sequencer for the iterative DIV/DIVU unit in the Execute stage.
//
// Latches the operands of a DIV/DIVU, runs a radix-2 restoring divide over
// WIDTH cycles, stalls the pipeline while it works, then presents quotient and
// remainder for a single-cycle HI/LO write. An Execute-stage flush abandons the
// divide so a cancelled instruction never writes HI/LO.
//
// Ports:
//   clk       in   system clock, rising edge
//   resetn    in   asynchronous active-low reset
//   start_i   in   Execute stage holds a valid DIV/DIVU
//   signed_i  in   1 = DIV (signed), 0 = DIVU
//   opa_i     in   dividend (rs after forwarding)
//   opb_i     in   divisor  (rt after forwarding)
//   cancel_i  in   Execute-stage flush
//   stall_o   out  stall request to the hazard unit
//   busy_o    out  state is not IDLE
//   ready_o   out  result valid, HI/LO write enable (one cycle)
//   quot_o    out  quotient  (to LO)
//   rem_o     out  remainder (to HI)
//
// Optional build macro: DIV_EARLY_OUT_EN
//   When defined, a divide by zero or a dividend magnitude smaller than the
//   divisor magnitude skips the iterative phase and goes straight to DONE.
// ---------------------------------------------------------------------------
module div_sched #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic             cancel_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] divisor_reg;   // |opb|
    logic [WIDTH-1:0] work_q_reg;    // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] part_rem_reg;  // partial remainder
    logic [WIDTH-1:0] raw_a_reg;     // raw dividend, returned as remainder on /0
    logic             sign_q_reg;
    logic             sign_r_reg;
    logic             div_zero_reg;
    logic [WIDTH-1:0] quot_reg;
    logic [WIDTH-1:0] rem_out_reg;

    // Operand magnitudes (only negated for signed divides).
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             start_ok;

    always_comb begin
        a_neg    = signed_i & opa_i[WIDTH-1];
        b_neg    = signed_i & opb_i[WIDTH-1];
        a_mag    = a_neg ? (~opa_i + 1'b1) : opa_i;
        b_mag    = b_neg ? (~opb_i + 1'b1) : opb_i;
        start_ok = start_i & ~cancel_i;
    end

`ifdef DIV_EARLY_OUT_EN
    logic early_out;
    always_comb begin
        early_out = (opb_i == '0) | (a_mag < b_mag);
    end
`endif

    // One restoring step. The partial remainder is always below the divisor,
    // so the shifted value plus one borrow bit fits in WIDTH+1 bits and the
    // top bit of the difference is the "trial subtract failed" indicator.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic [WIDTH-1:0] part_rem_next;
    logic [WIDTH-1:0] work_q_next;
    logic [WIDTH-1:0] quot_final;
    logic [WIDTH-1:0] rem_final;

    always_comb begin
        rem_shift     = {part_rem_reg, work_q_reg[WIDTH-1]};
        rem_diff      = rem_shift - {1'b0, divisor_reg};
        part_rem_next = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
        work_q_next   = {work_q_reg[WIDTH-2:0], ~rem_diff[WIDTH]};

        // Signs reapplied to the magnitudes; -MIN/-1 wraps back to MIN.
        quot_final = sign_q_reg ? (~work_q_next + 1'b1) : work_q_next;
        rem_final  = sign_r_reg ? (~part_rem_next + 1'b1) : part_rem_next;
        if (div_zero_reg) begin
            quot_final = '1;
            rem_final  = raw_a_reg;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            divisor_reg  <= '0;
            work_q_reg   <= '0;
            part_rem_reg <= '0;
            raw_a_reg    <= '0;
            sign_q_reg   <= 1'b0;
            sign_r_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            quot_reg     <= '0;
            rem_out_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        divisor_reg  <= b_mag;
                        work_q_reg   <= a_mag;
                        part_rem_reg <= '0;
                        raw_a_reg    <= opa_i;
                        sign_q_reg   <= signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
                        sign_r_reg   <= signed_i & opa_i[WIDTH-1];
                        div_zero_reg <= (opb_i == '0);
                        cnt_reg      <= '0;
`ifdef DIV_EARLY_OUT_EN
                        if (early_out) begin
                            // Quotient is trivially 0 (or all ones on /0) and
                            // the dividend is already the remainder.
                            state_reg   <= ST_DONE;
                            quot_reg    <= (opb_i == '0) ? '1 : '0;
                            rem_out_reg <= opa_i;
                        end else begin
                            state_reg <= ST_DIV;
                        end
`else
                        state_reg <= ST_DIV;
`endif
                    end
                end

                ST_DIV: begin
                    if (cancel_i) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        part_rem_reg <= part_rem_next;
                        work_q_reg   <= work_q_next;
                        cnt_reg      <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == LAST_CNT) begin
                            state_reg   <= ST_DONE;
                            quot_reg    <= quot_final;
                            rem_out_reg <= rem_final;
                        end
                    end
                end

                ST_DONE: begin
                    // start_i is still high for the instruction leaving E; ignore it.
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // stall_o is combinational so the hazard unit sees it in the same cycle
    // the divide is first presented; a flush drops it immediately.
    always_comb begin
        stall_o = resetn & ~cancel_i &
                  (((state_reg == ST_IDLE) & start_i) | (state_reg == ST_DIV));
        busy_o  = (state_reg != ST_IDLE);
        ready_o = (state_reg == ST_DONE) & ~cancel_i;
        quot_o  = quot_reg;
        rem_o   = rem_out_reg;
    end

endmodule

// File: tb/tb_div_sched.sv
// ---------------------------------------------------------------------------
// tb_div_sched -- directed self-checking bench for div_sched (WIDTH = 32).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_div_sched;

    logic        clk;
    logic        resetn;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic        cancel_i;
    logic        stall_o;
    logic        busy_o;
    logic        ready_o;
    logic [31:0] quot_o;
    logic [31:0] rem_o;

    int n_vec;
    int n_err;

`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif
    localparam int FULL_LAT = 33;

    div_sched #(.WIDTH(32)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (start_i),
        .signed_i (signed_i),
        .opa_i    (opa_i),
        .opb_i    (opb_i),
        .cancel_i (cancel_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .ready_o  (ready_o),
        .quot_o   (quot_o),
        .rem_o    (rem_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents a divide starting at the current falling edge and holds start_i
    // until the DONE cycle has passed. Cycle 0 is the cycle start is first seen.
    task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input int exp_lat);
        int stalls;
        int rdy_cyc;
        stalls   = 0;
        rdy_cyc  = -1;
        start_i  = 1'b1;
        signed_i = sgn;
        opa_i    = a;
        opb_i    = b;
        for (int c = 0; c < 40 && rdy_cyc < 0; c++) begin
            #1;
            if (stall_o) stalls++;
            if (ready_o) begin
                rdy_cyc = c;
                check({name, " quot"}, quot_o, exp_q);
                check({name, " rem"}, rem_o, exp_r);
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        check({name, " ready_cycle"}, 32'(rdy_cyc), 32'(exp_lat));
        check({name, " stall_cycles"}, 32'(stalls), 32'(exp_lat));
        $display("div %s: a=0x%08h b=0x%08h signed=%0b -> q=0x%08h r=0x%08h ready@%0d stall=%0d",
                 name, a, b, sgn, quot_o, rem_o, rdy_cyc, stalls);
    endtask

    initial begin
        int rdy_count;
        n_vec    = 0;
        n_err    = 0;
        resetn   = 1'b0;
        start_i  = 1'b0;
        signed_i = 1'b0;
        opa_i    = '0;
        opb_i    = '0;
        cancel_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset stall", 32'(stall_o), 32'd0);
        check("reset ready", 32'(ready_o), 32'd0);
        check("reset quot", quot_o, 32'd0);
        check("reset rem", rem_o, 32'd0);
        $display("reset: busy=%0b stall=%0b ready=%0b", busy_o, stall_o, ready_o);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Basic unsigned, then results hold while idle
        do_div("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, FULL_LAT);
        repeat (3) @(negedge clk);
        #1;
        check("hold quot", quot_o, 32'd14);
        check("hold rem", rem_o, 32'd2);
        check("hold busy", 32'(busy_o), 32'd0);
        $display("hold: q=0x%08h r=0x%08h busy=%0b", quot_o, rem_o, busy_o);
        @(negedge clk);

        // Signed cases issued back-to-back
        do_div("div_m7_2", 32'hFFFF_FFF9, 32'h2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, FULL_LAT);
        do_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, FULL_LAT);
        do_div("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, FULL_LAT);
        do_div("div_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, FULL_LAT);
        do_div("divu_big", 32'hFFFF_FFFF, 32'h0001_0000, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, FULL_LAT);

        // Early-out candidates
        do_div("divu_5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, EARLY_LAT);
        do_div("divu_3_9", 32'd3, 32'd9, 1'b0, 32'd0, 32'd3, EARLY_LAT);

        // Cancel in cycle 10 of a divide
        start_i  = 1'b1;
        signed_i = 1'b0;
        opa_i    = 32'd100;
        opb_i    = 32'd7;
        repeat (10) @(negedge clk);
        cancel_i = 1'b1;
        #1;
        check("cancel stall", 32'(stall_o), 32'd0);
        check("cancel busy_during", 32'(busy_o), 32'd1);
        @(negedge clk);
        cancel_i = 1'b0;
        start_i  = 1'b0;
        #1;
        check("cancel busy_after", 32'(busy_o), 32'd0);
        check("cancel quot_kept", quot_o, 32'd0);
        check("cancel rem_kept", rem_o, 32'd3);
        rdy_count = 0;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            #1;
            if (ready_o) rdy_count++;
        end
        check("cancel no_ready", 32'(rdy_count), 32'd0);
        $display("cancel: busy=%0b q=0x%08h r=0x%08h ready_pulses=%0d", busy_o, quot_o, rem_o, rdy_count);
        @(negedge clk);
        do_div("divu_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, FULL_LAT);

        // Asynchronous reset in cycle 15 of a divide (start_i left high)
        start_i  = 1'b1;
        signed_i = 1'b0;
        opa_i    = 32'd1000;
        opb_i    = 32'd7;
        repeat (15) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midreset busy", 32'(busy_o), 32'd0);
        check("midreset stall", 32'(stall_o), 32'd0);
        check("midreset ready", 32'(ready_o), 32'd0);
        check("midreset quot", quot_o, 32'd0);
        check("midreset rem", rem_o, 32'd0);
        $display("midreset: busy=%0b stall=%0b q=0x%08h r=0x%08h", busy_o, stall_o, quot_o, rem_o);
        @(negedge clk);
        start_i = 1'b0;
        resetn  = 1'b1;
        @(negedge clk);
        do_div("div_1000_33", 32'd1000, 32'd33, 1'b1, 32'd30, 32'd10, FULL_LAT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
